// File: rtl/mcycle_sequencer.sv
// mcycle_sequencer
//   Multi-cycle control sequencer for the 8-bit MIPS core (16-bit instructions).
//   Fetches an instruction over the shared memory port into IR, then steps
//   DECODE / EXEC / MEM / WB, one phase per cycle, producing the datapath
//   control signals, the memory handshake and the PC update strobes.
//
// Ports
//   clk, rst        core clock, synchronous active-high reset
//   mem_req/we/sel  memory request, write enable, 0=fetch 1=data access
//   mem_ack         memory completion (ignored while mem_req=0)
//   mem_rdata       fetch data, latched into IR on fetch ack
//   alu_flags       [0] carry, [1] zero, [2] larger; used in EXEC
//   ir              instruction register
//   pc_inc/pc_load  PC increment / PC load pulses
//   reg_write, reg_write_dst, alu_b_src_sel, mem_to_reg, alu_control
//                   datapath controls
//   state           FSM state (debug)
//   retired         retired-instruction counter (CNT_W bits, wraps)
//   illegal         sticky illegal-opcode flag
//
// Build option
//   SEQ_ILLEGAL_TRAP_EN  defined: illegal opcodes halt the sequencer and set
//                        'illegal'; undefined: illegal opcodes retire as NOP.

module mcycle_sequencer #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_sel,
    input  logic             mem_ack,
    input  logic [15:0]      mem_rdata,
    input  logic [7:0]       alu_flags,
    output logic [15:0]      ir,
    output logic             pc_inc,
    output logic             pc_load,
    output logic             reg_write,
    output logic             reg_write_dst,
    output logic             alu_b_src_sel,
    output logic             mem_to_reg,
    output logic [3:0]       alu_control,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired,
    output logic             illegal
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_e;

    typedef enum logic [3:0] {
        OP_JMP = 4'h0, OP_LD  = 4'h1, OP_ST  = 4'h2, OP_LI  = 4'h3,
        OP_ADD = 4'h4, OP_SUB = 4'h5, OP_AND = 4'h6, OP_OR  = 4'h7,
        OP_INV = 4'h8, OP_LSL = 4'h9, OP_LSR = 4'hA, OP_BEQ = 4'hB,
        OP_BNE = 4'hC, OP_RSD = 4'hD, OP_RSE = 4'hE, OP_SLT = 4'hF
    } opcode_e;

    state_e           state_q, state_d;
    logic [15:0]      ir_q, ir_d;
    logic [CNT_W-1:0] retired_q;
    logic             retire;
    opcode_e          op;
    logic             op_illegal;
    logic [3:0]       op_alu;

    // Only the zero flag steers the sequencer.
    logic unused_flags;
    assign unused_flags = ^{alu_flags[7:2], alu_flags[0]};

    assign op         = opcode_e'(ir_q[15:12]);
    assign op_illegal = (op == OP_RSD) || (op == OP_RSE);

    always_comb begin
        case (op)
            OP_LD, OP_ST, OP_ADD:    op_alu = 4'b0010;
            OP_SUB, OP_BEQ, OP_BNE:  op_alu = 4'b0011;
            OP_AND:                  op_alu = 4'b0001;
            OP_OR:                   op_alu = 4'b0100;
            OP_INV:                  op_alu = 4'b0101;
            OP_LSL:                  op_alu = 4'b0110;
            OP_LSR:                  op_alu = 4'b0111;
            OP_SLT:                  op_alu = 4'b1000;
            default:                 op_alu = 4'b0000;
        endcase
    end

`ifdef SEQ_ILLEGAL_TRAP_EN
    logic ill_q;
    logic trap;
`endif

    // Next-state logic
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        retire  = 1'b0;
`ifdef SEQ_ILLEGAL_TRAP_EN
        trap    = 1'b0;
`endif
        case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: begin
                if (mem_ack) begin
                    ir_d    = mem_rdata;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (op == OP_JMP) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (op_illegal) begin
`ifdef SEQ_ILLEGAL_TRAP_EN
                    trap    = 1'b1;
                    state_d = S_HALT;
`else
                    retire  = 1'b1;
                    state_d = S_FETCH;
`endif
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (op == OP_BEQ || op == OP_BNE) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (op == OP_LD || op == OP_ST) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (mem_ack) begin
                    if (op == OP_ST) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ir_q      <= '0;
            retired_q <= '0;
`ifdef SEQ_ILLEGAL_TRAP_EN
            ill_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            if (retire) begin
                retired_q <= retired_q + CNT_W'(1);
            end
`ifdef SEQ_ILLEGAL_TRAP_EN
            if (trap) begin
                ill_q <= 1'b1;
            end
`endif
        end
    end

    // Moore-style output decode from state and IR; the EXEC branch decision
    // is the only path that looks at alu_flags, and the fetch-ack cycle is the
    // only one that looks at mem_ack (pc_inc pulses as IR is loaded).
    always_comb begin
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_sel       = 1'b0;
        pc_inc        = 1'b0;
        pc_load       = 1'b0;
        reg_write     = 1'b0;
        reg_write_dst = 1'b0;
        alu_b_src_sel = 1'b0;
        mem_to_reg    = 1'b0;
        alu_control   = 4'b0000;
        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                pc_inc  = mem_ack;
            end
            S_DECODE: begin
                pc_load = (op == OP_JMP);
            end
            S_EXEC: begin
                alu_control   = op_alu;
                alu_b_src_sel = !(op == OP_LD || op == OP_ST || op == OP_LI);
                if (op == OP_BEQ) begin
                    pc_load = alu_flags[1];
                end else if (op == OP_BNE) begin
                    pc_load = !alu_flags[1];
                end
            end
            S_MEM: begin
                mem_req     = 1'b1;
                mem_sel     = 1'b1;
                mem_we      = (op == OP_ST);
                alu_control = op_alu;
            end
            S_WB: begin
                reg_write     = 1'b1;
                reg_write_dst = (op == OP_LD || op == OP_LI);
                mem_to_reg    = (op == OP_LD);
                alu_control   = op_alu;
            end
            default: ;
        endcase
    end

    assign state   = state_q;
    assign ir      = ir_q;
    assign retired = retired_q;
`ifdef SEQ_ILLEGAL_TRAP_EN
    assign illegal = ill_q;
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_mcycle_sequencer.sv
// Self-checking bench for mcycle_sequencer: a reference model pushes the
// expected per-cycle outputs of each instruction into a scoreboard queue while
// a reactive memory model serves fetches/data accesses with programmable wait
// cycles; every cycle pops one expected record and compares it to the DUT.
module tb_mcycle_sequencer;

    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_req, mem_we, mem_sel, mem_ack;
    logic [15:0]   mem_rdata;
    logic [7:0]    alu_flags;
    logic [15:0]   ir;
    logic          pc_inc, pc_load, reg_write, reg_write_dst;
    logic          alu_b_src_sel, mem_to_reg;
    logic [3:0]    alu_control;
    logic [2:0]    state;
    logic [CW-1:0] retired;
    logic          illegal;

    always #5 clk = ~clk;

    mcycle_sequencer #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .alu_flags(alu_flags),
        .ir(ir), .pc_inc(pc_inc), .pc_load(pc_load),
        .reg_write(reg_write), .reg_write_dst(reg_write_dst),
        .alu_b_src_sel(alu_b_src_sel), .mem_to_reg(mem_to_reg),
        .alu_control(alu_control), .state(state), .retired(retired),
        .illegal(illegal)
    );

    typedef struct packed {
        logic [2:0]    st;
        logic          req;
        logic          we;
        logic          sel;
        logic          pinc;
        logic          pld;
        logic          rw;
        logic          rwd;
        logic          bsel;
        logic          m2r;
        logic [3:0]    aluc;
        logic          ill;
        logic [15:0]   ir;
        logic [CW-1:0] ret;
    } rec_t;

    rec_t          exp_q[$];
    logic [15:0]   p_instr[$];
    int unsigned   p_fw[$];
    int unsigned   p_mw[$];
    logic [7:0]    p_fl[$];
    int unsigned   fetch_idx, cur_idx, wc;
    logic          have_cur;

    logic [15:0]   m_ir;
    logic [CW-1:0] m_ret;
    logic          m_ill;

    int total = 0;
    int bad   = 0;

    logic [3:0] legal_ops [14] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6,
                                   4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hF};

    function automatic rec_t mk(input logic [2:0] st);
        rec_t r;
        r     = '0;
        r.st  = st;
        r.ir  = m_ir;
        r.ret = m_ret;
        r.ill = m_ill;
        return r;
    endfunction

    function automatic logic [3:0] ref_alu(input logic [3:0] op);
        case (op)
            4'h1, 4'h2, 4'h4: return 4'b0010;
            4'h5, 4'hB, 4'hC: return 4'b0011;
            4'h6:             return 4'b0001;
            4'h7:             return 4'b0100;
            4'h8:             return 4'b0101;
            4'h9:             return 4'b0110;
            4'hA:             return 4'b0111;
            4'hF:             return 4'b1000;
            default:          return 4'b0000;
        endcase
    endfunction

    // Queue one instruction for the memory model and push its expected trace.
    task automatic add_instr(input logic [15:0] ins, input int unsigned fw,
                             input int unsigned mw, input logic [7:0] fl);
        logic [3:0] op;
        rec_t r;
        p_instr.push_back(ins);
        p_fw.push_back(fw);
        p_mw.push_back(mw);
        p_fl.push_back(fl);
        for (int unsigned i = 0; i < fw; i++) begin
            r = mk(3'd1); r.req = 1'b1; exp_q.push_back(r);
        end
        r = mk(3'd1); r.req = 1'b1; r.pinc = 1'b1; exp_q.push_back(r);
        m_ir = ins;
        op   = ins[15:12];
        r = mk(3'd2); r.pld = (op == 4'h0); exp_q.push_back(r);
        if (op == 4'h0) begin
            m_ret++;
            return;
        end
        if (op == 4'hD || op == 4'hE) begin
`ifdef SEQ_ILLEGAL_TRAP_EN
            m_ill = 1'b1;
            for (int unsigned i = 0; i < 4; i++) exp_q.push_back(mk(3'd6));
`else
            m_ret++;
`endif
            return;
        end
        r = mk(3'd3);
        r.aluc = ref_alu(op);
        r.bsel = !(op == 4'h1 || op == 4'h2 || op == 4'h3);
        if (op == 4'hB) r.pld = fl[1];
        if (op == 4'hC) r.pld = !fl[1];
        exp_q.push_back(r);
        if (op == 4'hB || op == 4'hC) begin
            m_ret++;
            return;
        end
        if (op == 4'h1 || op == 4'h2) begin
            for (int unsigned i = 0; i <= mw; i++) begin
                r = mk(3'd4); r.req = 1'b1; r.sel = 1'b1;
                r.we = (op == 4'h2); r.aluc = 4'b0010;
                exp_q.push_back(r);
            end
            if (op == 4'h2) begin
                m_ret++;
                return;
            end
        end
        r = mk(3'd5);
        r.rw   = 1'b1;
        r.rwd  = (op == 4'h1 || op == 4'h3);
        r.m2r  = (op == 4'h1);
        r.aluc = ref_alu(op);
        exp_q.push_back(r);
        m_ret++;
    endtask

    // One cycle: drive memory/flags reactively at the negedge, sample 1ns later.
    task automatic step(output rec_t a);
        int unsigned tgt;
        mem_rdata = 16'($urandom);
        if (mem_req) begin
            if (!mem_sel) tgt = (fetch_idx < p_fw.size()) ? p_fw[fetch_idx] : 0;
            else          tgt = have_cur ? p_mw[cur_idx] : 0;
            if (wc >= tgt) begin
                mem_ack = 1'b1;
                wc      = 0;
                if (!mem_sel) begin
                    have_cur  = (fetch_idx < p_instr.size());
                    mem_rdata = have_cur ? p_instr[fetch_idx] : 16'h0000;
                    cur_idx   = fetch_idx;
                    fetch_idx++;
                end
            end else begin
                mem_ack = 1'b0;
                wc++;
            end
        end else begin
            mem_ack = 1'b1;   // must be ignored while no request is pending
            wc      = 0;
        end
        alu_flags = have_cur ? p_fl[cur_idx] : 8'h00;
        #1;
        a.st   = state;         a.req  = mem_req;    a.we   = mem_we;
        a.sel  = mem_sel;       a.pinc = pc_inc;     a.pld  = pc_load;
        a.rw   = reg_write;     a.rwd  = reg_write_dst;
        a.bsel = alu_b_src_sel; a.m2r  = mem_to_reg; a.aluc = alu_control;
        a.ill  = illegal;       a.ir   = ir;         a.ret  = retired;
        @(negedge clk);
    endtask

    task automatic do_reset(input int unsigned n);
        rst     = 1'b1;
        mem_ack = 1'b0;
        repeat (n) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete(); p_instr.delete(); p_fw.delete();
        p_mw.delete();  p_fl.delete();
        fetch_idx = 0; cur_idx = 0; wc = 0; have_cur = 1'b0;
        m_ir = '0; m_ret = '0; m_ill = 1'b0;
        exp_q.push_back(mk(3'd0));
    endtask

    task automatic test_reset;
        rec_t e, a;
        int cyc = 0;
        do_reset(2);
        add_instr(16'h4123, 0, 0, 8'h00);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); step(a); total++; cyc++;
            if (a !== e) begin
                bad++;
                $display("FAIL reset_add cyc=%0d got=%h exp=%h", cyc, a, e);
            end
        end
        total++;
        if (retired !== m_ret) begin
            bad++;
            $display("FAIL reset_add_retired got=%0d exp=%0d", retired, m_ret);
        end
    endtask

    task automatic test_alu_ops;
        rec_t e, a;
        int cyc = 0;
        logic [3:0] ops [9] = '{4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hF, 4'h3, 4'h4};
        foreach (ops[i])
            add_instr({ops[i], 12'($urandom)}, $urandom_range(0, 2), 0, 8'($urandom));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); step(a); total++; cyc++;
            if (a !== e) begin
                bad++;
                $display("FAIL alu_ops cyc=%0d got=%h exp=%h", cyc, a, e);
            end
        end
    endtask

    task automatic test_load;
        rec_t e, a;
        int cyc = 0;
        add_instr(16'h1234, 2, 2, 8'h00);
        total++;
        if (exp_q.size() !== 9) begin
            bad++;
            $display("FAIL load_len got=%0d exp=9", exp_q.size());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); step(a); total++; cyc++;
            if (a !== e) begin
                bad++;
                $display("FAIL load cyc=%0d got=%h exp=%h", cyc, a, e);
            end
        end
    endtask

    task automatic test_branch;
        rec_t e, a;
        int cyc = 0;
        add_instr(16'hB123, 0, 0, 8'h02);
        add_instr(16'hC123, 0, 0, 8'h02);
        add_instr(16'hC456, 1, 0, 8'h00);
        add_instr(16'hB456, 0, 0, 8'hFD);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); step(a); total++; cyc++;
            if (a !== e) begin
                bad++;
                $display("FAIL branch cyc=%0d got=%h exp=%h", cyc, a, e);
            end
        end
    endtask

    task automatic test_store_jmp;
        rec_t e, a;
        int cyc = 0;
        add_instr(16'h2345, 0, 3, 8'h00);
        add_instr(16'h0010, 0, 0, 8'h00);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); step(a); total++; cyc++;
            if (a !== e) begin
                bad++;
                $display("FAIL store_jmp cyc=%0d got=%h exp=%h", cyc, a, e);
            end
        end
        total++;
        if (retired !== m_ret) begin
            bad++;
            $display("FAIL store_jmp_retired got=%0d exp=%0d", retired, m_ret);
        end
    endtask

    task automatic test_reset_mid_mem;
        rec_t e, a;
        int cyc = 0;
        add_instr(16'h1456, 0, 5, 8'h00);
        // FETCH, DECODE, EXEC, then two MEM wait cycles.
        for (int i = 0; i < 5; i++) begin
            e = exp_q.pop_front(); step(a); total++; cyc++;
            if (a !== e) begin
                bad++;
                $display("FAIL mid_mem_pre cyc=%0d got=%h exp=%h", cyc, a, e);
            end
        end
        do_reset(1);
        add_instr(16'h4ABC, 0, 0, 8'h00);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); step(a); total++; cyc++;
            if (a !== e) begin
                bad++;
                $display("FAIL mid_mem_post cyc=%0d got=%h exp=%h", cyc, a, e);
            end
        end
    endtask

    task automatic test_back_to_back;
        rec_t e, a;
        int cyc = 0;
        for (int i = 0; i < 22; i++)
            add_instr({legal_ops[$urandom_range(0, 13)], 12'($urandom)},
                      $urandom_range(0, 2), $urandom_range(0, 2), 8'($urandom));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); step(a); total++; cyc++;
            if (a !== e) begin
                bad++;
                $display("FAIL back_to_back cyc=%0d got=%h exp=%h", cyc, a, e);
            end
        end
        total++;
        if (retired !== m_ret) begin
            bad++;
            $display("FAIL wrap_retired got=%0d exp=%0d", retired, m_ret);
        end
    endtask

    task automatic test_illegal;
        rec_t e, a;
        int cyc = 0;
        add_instr(16'hD000, 0, 0, 8'h00);
`ifndef SEQ_ILLEGAL_TRAP_EN
        add_instr(16'h4321, 1, 0, 8'h00);
`endif
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); step(a); total++; cyc++;
            if (a !== e) begin
                bad++;
                $display("FAIL illegal cyc=%0d got=%h exp=%h", cyc, a, e);
            end
        end
        total++;
        if (illegal !== m_ill || retired !== m_ret) begin
            bad++;
            $display("FAIL illegal_final got=%b/%0d exp=%b/%0d",
                     illegal, retired, m_ill, m_ret);
        end
    endtask

    initial begin
        rst       = 1'b1;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        alu_flags = '0;
        test_reset();
        test_alu_ops();
        test_load();
        test_branch();
        test_store_jmp();
        test_reset_mid_mem();
        test_back_to_back();
        test_illegal();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
